// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command-side controller.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned MODE_W    = 2;
    localparam int unsigned EN_W      = 3;
    localparam int unsigned IRQ_CNT_W = 8;

    // ALU path selected by a command
    typedef enum logic [MODE_W-1:0] {
        MODE_NOP = 2'b00,
        MODE_A   = 2'b01,
        MODE_B   = 2'b10,
        MODE_ILL = 2'b11
    } alu_mode_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_CAPT = 3'd2,
        ST_CLR  = 3'd3,
        ST_RESP = 3'd4
    } ctrl_state_e;

    // Enable triplets ordered {alu_enable, alu_enable_a, alu_enable_b}
    localparam logic [EN_W-1:0] EN_NONE   = 3'b000;
    localparam logic [EN_W-1:0] EN_A_PATH = 3'b110;
    localparam logic [EN_W-1:0] EN_B_PATH = 3'b101;
    localparam logic [EN_W-1:0] EN_ILL    = 3'b111;

endpackage

// File: rtl/alu_ctrl_mode_dec.sv
// Combinational decode of command mode/op into ALU enables and opcodes.
module alu_ctrl_mode_dec
    import alu_ctrl_pkg::*;
(
    input  alu_mode_e         mode_i,
    input  logic [OP_W-1:0]   op_i,
    output logic [EN_W-1:0]   en_c,
    output logic [OP_W-1:0]   op_a_c,
    output logic [OP_W-1:0]   op_b_c
);

    // Route op to the selected path; the unused opcode stays 00
    always_comb begin
        en_c   = EN_NONE;
        op_a_c = '0;
        op_b_c = '0;
        case (mode_i)
            MODE_A: begin
                en_c   = EN_A_PATH;
                op_a_c = op_i;
            end
            MODE_B: begin
                en_c   = EN_B_PATH;
                op_b_c = op_i;
            end
            MODE_ILL: en_c = EN_ILL;
            default:  en_c = EN_NONE;
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the 8-bit ALU: command handshake, ALU drive,
// result/interrupt capture, interrupt clear and response handshake.
// Optional saturating interrupt counter enabled by ALU_CTRL_IRQ_CNT_EN.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_irq,
    output logic              alu_enable,
    output logic              alu_enable_a,
    output logic              alu_enable_b,
    output logic [OP_W-1:0]   alu_op_a,
    output logic [OP_W-1:0]   alu_op_b,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic              alu_irq_clr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_irq
`ifdef ALU_CTRL_IRQ_CNT_EN
    ,
    output logic [IRQ_CNT_W-1:0] irq_cnt
`endif
);

    ctrl_state_e       state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_irq_q, rsp_irq_d;
    logic [EN_W-1:0]   en_q, en_d;
    logic [OP_W-1:0]   op_a_q, op_a_d;
    logic [OP_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0] in_a_q, in_a_d;
    logic [DATA_W-1:0] in_b_q, in_b_d;
    logic              irq_clr_q, irq_clr_d;
    logic              ill_q, ill_d;

    logic [EN_W-1:0]   dec_en_c;
    logic [OP_W-1:0]   dec_op_a_c, dec_op_b_c;
    logic              cmd_hs_c, rsp_hs_c;

    assign cmd_hs_c = cmd_valid & cmd_ready_q;
    assign rsp_hs_c = rsp_valid_q & rsp_ready;

    alu_ctrl_mode_dec u_mode_dec (
        .mode_i (alu_mode_e'(cmd_mode)),
        .op_i   (cmd_op),
        .en_c   (dec_en_c),
        .op_a_c (dec_op_a_c),
        .op_b_c (dec_op_b_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: one command in flight, clear cycle only on interrupt
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_hs_c) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_CAPT;
            ST_CAPT: state_d = alu_irq ? ST_CLR : ST_RESP;
            ST_CLR:  state_d = ST_RESP;
            ST_RESP: if (rsp_hs_c) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; flags follow the state being entered so the clear
    // pulse and the enables can never overlap
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        irq_clr_d   = (state_d == ST_CLR);
        en_d        = EN_NONE;
        rsp_data_d  = rsp_data_q;
        rsp_irq_d   = rsp_irq_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        in_a_d      = in_a_q;
        in_b_d      = in_b_q;
        ill_d       = ill_q;
        if (state_q == ST_IDLE && cmd_hs_c) begin
            en_d   = dec_en_c;
            op_a_d = dec_op_a_c;
            op_b_d = dec_op_b_c;
            in_a_d = cmd_a;
            in_b_d = cmd_b;
            ill_d  = (alu_mode_e'(cmd_mode) == MODE_ILL);
        end
        if (state_q == ST_CAPT) begin
            rsp_data_d = ill_q ? '0 : alu_out;
            rsp_irq_d  = alu_irq;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_irq_q   <= 1'b0;
            en_q        <= EN_NONE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            irq_clr_q   <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_irq_q   <= rsp_irq_d;
            en_q        <= en_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            irq_clr_q   <= irq_clr_d;
            ill_q       <= ill_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_irq      = rsp_irq_q;
    assign alu_enable   = en_q[2];
    assign alu_enable_a = en_q[1];
    assign alu_enable_b = en_q[0];
    assign alu_op_a     = op_a_q;
    assign alu_op_b     = op_b_q;
    assign alu_in_a     = in_a_q;
    assign alu_in_b     = in_b_q;
    assign alu_irq_clr  = irq_clr_q;

`ifdef ALU_CTRL_IRQ_CNT_EN
    logic [IRQ_CNT_W-1:0] irq_cnt_q, irq_cnt_d;

    // Count entries into the clear state, saturating at all-ones
    always_comb begin
        irq_cnt_d = irq_cnt_q;
        if (state_q == ST_CAPT && state_d == ST_CLR && irq_cnt_q != {IRQ_CNT_W{1'b1}})
            irq_cnt_d = irq_cnt_q + IRQ_CNT_W'(1);
    end

    // Interrupt counter register
    always_ff @(posedge clk) begin
        if (!rst_n) irq_cnt_q <= '0;
        else        irq_cnt_q <= irq_cnt_d;
    end

    assign irq_cnt = irq_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl with a behavioural ALU model and a
// response scoreboard. Interrupt counter checks run when ALU_CTRL_IRQ_CNT_EN
// is defined.
module tb_alu_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a, cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_irq;
    logic       alu_enable, alu_enable_a, alu_enable_b;
    logic [1:0] alu_op_a, alu_op_b;
    logic [7:0] alu_in_a, alu_in_b;
    logic       alu_irq_clr;
    logic [7:0] alu_out;
    logic       alu_irq;
`ifdef ALU_CTRL_IRQ_CNT_EN
    logic [7:0] irq_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] sb[$];        // expected {irq, data} per accepted command
    logic [7:0] ref_out;      // predicted retained ALU output
    logic       ref_stale;    // predicted stale interrupt pending
    logic       stale_inj;

    wire [34:0] outs_w = {cmd_ready, rsp_valid, rsp_data, rsp_irq, alu_enable, alu_enable_a,
                          alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b, alu_irq_clr};

    alu_cmd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_irq      (rsp_irq),
        .alu_enable   (alu_enable),
        .alu_enable_a (alu_enable_a),
        .alu_enable_b (alu_enable_b),
        .alu_op_a     (alu_op_a),
        .alu_op_b     (alu_op_b),
        .alu_in_a     (alu_in_a),
        .alu_in_b     (alu_in_b),
        .alu_irq_clr  (alu_irq_clr),
        .alu_out      (alu_out),
        .alu_irq      (alu_irq)
`ifdef ALU_CTRL_IRQ_CNT_EN
        ,
        .irq_cnt      (irq_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {irq_trigger, result}
    function automatic logic [8:0] alu_fn(input logic ea, input logic eb, input logic [1:0] opa,
                                          input logic [1:0] opb, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] trig;
        r = 8'h00;
        trig = 8'h00;
        if (ea && eb) return 9'h000;
        if (ea) begin
            case (opa)
                2'b00: begin r = a & b;    trig = 8'hFF; end
                2'b01: begin r = ~(a & b); trig = 8'h00; end
                2'b10: begin r = a | b;    trig = 8'hF8; end
                default: begin r = a ^ b; trig = 8'h83; end
            endcase
        end else if (eb) begin
            case (opb)
                2'b00: begin r = ~(a ^ b); trig = 8'hF1; end
                2'b01: begin r = a & b;    trig = 8'hF4; end
                2'b10: begin r = ~(a | b); trig = 8'hF5; end
                default: begin r = a | b; trig = 8'hFF; end
            endcase
        end else begin
            return 9'h000;
        end
        return {r == trig, r};
    endfunction

    wire [8:0] alu_calc = alu_fn(alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b);

    // Behavioural ALU: registered result, sticky interrupt, shares reset
    always @(posedge clk) begin
        if (!rst_n) begin
            alu_out <= 8'h00;
            alu_irq <= 1'b0;
        end else begin
            if (alu_irq_clr) alu_irq <= 1'b0;
            if (alu_enable) begin
                alu_out <= alu_calc[7:0];
                if (alu_calc[8]) alu_irq <= 1'b1;
            end
            if (stale_inj) alu_irq <= 1'b1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1);
    end

    // Predict the response of an accepted command and queue it
    function automatic void predict(input logic [1:0] mode, input logic [1:0] op,
                                    input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (mode)
            2'b00: r = {ref_stale, ref_out};
            2'b11: begin r = {ref_stale, 8'h00}; ref_out = 8'h00; end
            2'b01: begin r = alu_fn(1'b1, 1'b0, op, 2'b00, a, b); r[8] = r[8] | ref_stale; ref_out = r[7:0]; end
            default: begin r = alu_fn(1'b0, 1'b1, 2'b00, op, a, b); r[8] = r[8] | ref_stale; ref_out = r[7:0]; end
        endcase
        ref_stale = 1'b0;
        sb.push_back(r);
    endfunction

    function automatic logic [8:0] pop_exp();
        if (sb.size() == 0) return 9'bx;
        return sb.pop_front();
    endfunction

    // Drive one command and return {accepted, ALU drive seen in EXEC}
    task automatic send_cmd(input logic [1:0] mode, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] b, output logic [23:0] drv);
        int n;
        logic ok;
        n = 0;
        cmd_mode = mode; cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = cmd_ready;
        @(posedge clk);
        if (ok) predict(mode, op, a, b);
        #1;
        cmd_valid = 1'b0;
        drv = {ok, alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b};
    endtask

    // Observe from the EXEC cycle until rsp_valid (bounded)
    task automatic wait_rsp(output logic [39:0] tim, output logic irq_v);
        int lat, en_cnt, clr_cnt, ovl_cnt, rdy_cnt;
        lat = 0; en_cnt = 0; clr_cnt = 0; ovl_cnt = 0; rdy_cnt = 0; irq_v = 1'bx;
        forever begin
            if (alu_enable | alu_enable_a | alu_enable_b) en_cnt++;
            if (alu_irq_clr) clr_cnt++;
            if (alu_irq_clr && (alu_enable | alu_enable_a | alu_enable_b)) ovl_cnt++;
            if (cmd_ready) rdy_cnt++;
            if (rsp_valid) begin
                irq_v = alu_irq;
                break;
            end
            if (lat >= 30) break;
            @(posedge clk); #1; lat++;
        end
        tim = {8'(lat), 8'(en_cnt), 8'(clr_cnt), 8'(ovl_cnt), 8'(rdy_cnt)};
    endtask

    task automatic run_cmd(input logic [1:0] mode, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] b, output logic [23:0] drv, output logic [8:0] got,
                           output logic [8:0] exp, output logic [39:0] tim, output logic irq_v);
        send_cmd(mode, op, a, b, drv);
        wait_rsp(tim, irq_v);
        got = {rsp_irq, rsp_data};
        exp = pop_exp();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        ref_out = 8'h00;
        ref_stale = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs_w !== 35'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs_w); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_release: got ready/valid %b expected 10", {cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_no_irq();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        run_cmd(2'b01, 2'b00, 8'h0F, 8'hF3, drv, got, exp, tim, iv);
        checks++;
        if (drv !== {1'b1, 3'b110, 2'b00, 2'b00, 8'h0F, 8'hF3}) begin errors++; $display("FAIL no_irq_drive: got %h expected %h", drv, {1'b1, 3'b110, 2'b00, 2'b00, 8'h0F, 8'hF3}); end
        checks++;
        if (got !== exp || got !== 9'h003) begin errors++; $display("FAIL no_irq_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h02_01_00_00_00) begin errors++; $display("FAIL no_irq_timing: got %h expected 0201000000", tim); end
        @(posedge clk); #1;
    endtask

    task automatic test_irq();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        run_cmd(2'b01, 2'b00, 8'hFF, 8'hFF, drv, got, exp, tim, iv);
        checks++;
        if (got !== exp || got !== 9'h1FF) begin errors++; $display("FAIL irq_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h03_01_01_00_00) begin errors++; $display("FAIL irq_timing: got %h expected 0301010000", tim); end
        checks++;
        if (iv !== 1'b0) begin errors++; $display("FAIL irq_cleared_at_valid: got %b expected 0", iv); end
        @(posedge clk); #1;
    endtask

    task automatic test_b_path_illegal();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        run_cmd(2'b10, 2'b11, 8'hF0, 8'h0F, drv, got, exp, tim, iv);
        checks++;
        if (drv !== {1'b1, 3'b101, 2'b00, 2'b11, 8'hF0, 8'h0F}) begin errors++; $display("FAIL b_drive: got %h", drv); end
        checks++;
        if (got !== exp || got !== 9'h1FF) begin errors++; $display("FAIL b_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h03_01_01_00_00) begin errors++; $display("FAIL b_timing: got %h expected 0301010000", tim); end
        @(posedge clk); #1;
        run_cmd(2'b11, 2'b01, 8'h55, 8'hAA, drv, got, exp, tim, iv);
        checks++;
        if (drv !== {1'b1, 3'b111, 2'b00, 2'b00, 8'h55, 8'hAA}) begin errors++; $display("FAIL ill_drive: got %h", drv); end
        checks++;
        if (got !== exp || got !== 9'h000) begin errors++; $display("FAIL ill_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h02_01_00_00_00) begin errors++; $display("FAIL ill_timing: got %h expected 0201000000", tim); end
        @(posedge clk); #1;
    endtask

    task automatic test_nop_stale();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        logic [2:0] idle_bad;
        run_cmd(2'b01, 2'b11, 8'h12, 8'h34, drv, got, exp, tim, iv);
        checks++;
        if (got !== exp || got !== 9'h026) begin errors++; $display("FAIL xor_data: got %h expected %h", got, exp); end
        @(posedge clk); #1;
        stale_inj = 1'b1;
        ref_stale = 1'b1;
        @(posedge clk); #1;
        stale_inj = 1'b0;
        idle_bad = 3'b000;
        repeat (3) begin
            @(posedge clk); #1;
            if ({cmd_ready, rsp_valid, alu_irq_clr} !== 3'b100) idle_bad = {cmd_ready, rsp_valid, alu_irq_clr};
        end
        checks++;
        if (idle_bad !== 3'b000) begin errors++; $display("FAIL stale_idle: got ready/valid/clr %b expected 100", idle_bad); end
        run_cmd(2'b00, 2'b10, 8'hAA, 8'hBB, drv, got, exp, tim, iv);
        checks++;
        if (drv !== {1'b1, 3'b000, 2'b00, 2'b00, 8'hAA, 8'hBB}) begin errors++; $display("FAIL nop_drive: got %h", drv); end
        checks++;
        if (got !== exp || got !== 9'h126) begin errors++; $display("FAIL nop_stale_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h03_00_01_00_00) begin errors++; $display("FAIL nop_stale_timing: got %h expected 0300010000", tim); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [23:0] drv; logic [8:0] got, exp, held; logic [39:0] tim; logic iv;
        rsp_ready = 1'b0;
        send_cmd(2'b01, 2'b01, 8'hF0, 8'h0F, drv);
        wait_rsp(tim, iv);
        held = {rsp_irq, rsp_data};
        exp = pop_exp();
        checks++;
        if (held !== exp || held !== 9'h0FF) begin errors++; $display("FAIL bp_data: got %h expected %h", held, exp); end
        cmd_mode = 2'b10; cmd_op = 2'b00; cmd_a = 8'h0E; cmd_b = 8'h00; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_irq, rsp_data, cmd_ready} !== {1'b1, held, 1'b0}) begin
                errors++; $display("FAIL bp_hold cycle %0d: got %h expected %h", i, {rsp_valid, rsp_irq, rsp_data, cmd_ready}, {1'b1, held, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_handshake: got valid/ready %b expected 01", {rsp_valid, cmd_ready}); end
        @(posedge clk);
        predict(2'b10, 2'b00, 8'h0E, 8'h00);
        #1;
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, alu_enable, alu_enable_a, alu_enable_b, alu_in_a} !== {1'b0, 3'b101, 8'h0E}) begin
            errors++; $display("FAIL b2b_accept: got %h expected %h", {cmd_ready, alu_enable, alu_enable_a, alu_enable_b, alu_in_a}, {1'b0, 3'b101, 8'h0E});
        end
        wait_rsp(tim, iv);
        got = {rsp_irq, rsp_data};
        exp = pop_exp();
        checks++;
        if (got !== exp || got !== 9'h1F1) begin errors++; $display("FAIL b2b_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h03_01_01_00_00) begin errors++; $display("FAIL b2b_timing: got %h expected 0301010000", tim); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_clr();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        int n;
        send_cmd(2'b01, 2'b00, 8'hFF, 8'hFF, drv);
        n = 0;
        while (!alu_irq_clr && n < 10) begin @(posedge clk); #1; n++; end
        checks++;
        if (alu_irq_clr !== 1'b1) begin errors++; $display("FAIL rst_clr_reach: got clr %b expected 1", alu_irq_clr); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (outs_w !== 35'd0) begin errors++; $display("FAIL rst_clr_outputs: got %h expected 0", outs_w); end
        rst_n = 1'b1;
        sb.delete();
        ref_out = 8'h00;
        ref_stale = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cmd_ready, rsp_valid, alu_irq} !== 3'b100) begin errors++; $display("FAIL rst_clr_release: got %b expected 100", {cmd_ready, rsp_valid, alu_irq}); end
        run_cmd(2'b01, 2'b10, 8'hF0, 8'h08, drv, got, exp, tim, iv);
        checks++;
        if (got !== exp || got !== 9'h1F8) begin errors++; $display("FAIL rst_clr_next_data: got %h expected %h", got, exp); end
        checks++;
        if (tim !== 40'h03_01_01_00_00) begin errors++; $display("FAIL rst_clr_next_timing: got %h expected 0301010000", tim); end
        @(posedge clk); #1;
    endtask

`ifdef ALU_CTRL_IRQ_CNT_EN
    task automatic test_irq_cnt();
        logic [23:0] drv; logic [8:0] got, exp; logic [39:0] tim; logic iv;
        do_reset();
        checks++;
        if (irq_cnt !== 8'd0) begin errors++; $display("FAIL irq_cnt_reset: got %0d expected 0", irq_cnt); end
        for (int i = 0; i < 3; i++) run_cmd(2'b01, 2'b00, 8'hFF, 8'hFF, drv, got, exp, tim, iv);
        checks++;
        if (irq_cnt !== 8'd3) begin errors++; $display("FAIL irq_cnt_three: got %0d expected 3", irq_cnt); end
        for (int i = 0; i < 297; i++) run_cmd(2'b01, 2'b00, 8'hFF, 8'hFF, drv, got, exp, tim, iv);
        checks++;
        if (irq_cnt !== 8'hFF) begin errors++; $display("FAIL irq_cnt_sat: got %0d expected 255", irq_cnt); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_mode = 2'b00;
        cmd_op = 2'b00;
        cmd_a = 8'h00;
        cmd_b = 8'h00;
        rsp_ready = 1'b1;
        stale_inj = 1'b0;
        ref_out = 8'h00;
        ref_stale = 1'b0;
        test_reset();
        test_no_irq();
        test_irq();
        test_b_path_illegal();
        test_nop_stale();
        test_back_to_back();
        test_reset_in_clr();
`ifdef ALU_CTRL_IRQ_CNT_EN
        test_irq_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
